polytocanonical: RTL and testbench



---
 rtl/polytocanonical.sv | 128 ++++++++++++
 tb/tb_polytocanonical.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/polytocanonical.sv
// Serial signed-digit to canonical residue converter: carries ripple one digit
// per cycle, then the accumulated value is folded into [0, MODULUS) by add/sub.
module polytocanonical #(
  parameter int unsigned NUMSYMBOLS = 4,
  parameter int unsigned LOGRADIX   = 4,
  parameter logic [NUMSYMBOLS*LOGRADIX-1:0] MODULUS = 16'hFFF1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUMSYMBOLS*(LOGRADIX+2)-1:0]    data_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NUMSYMBOLS*LOGRADIX-1:0]        data_out
);

  localparam int unsigned W    = NUMSYMBOLS * LOGRADIX;
  localparam int unsigned DW   = LOGRADIX + 2;
  localparam int unsigned AW   = W + 3;
  localparam int unsigned IDXW = (NUMSYMBOLS > 1) ? $clog2(NUMSYMBOLS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NUMSYMBOLS - 1);

  if (MODULUS[W-1] != 1'b1) begin : g_bad_modulus
    $error("polytocanonical: MODULUS must lie in [2^(W-1), 2^W)");
  end

  typedef enum logic [1:0] {IDLE, CARRY, REDUCE, DONE} state_t;

  state_t                   state_q, state_d;
  logic [NUMSYMBOLS*DW-1:0] digits_q, digits_d;
  logic [W-1:0]             low_q, low_d;
  logic signed [2:0]        carry_q, carry_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [W-1:0]             dout_q, dout_d;

  logic [DW-1:0]            digit;
  logic signed [DW:0]       t;
  logic [W-1:0]             low_upd;
  logic signed [AW-1:0]     mod_ext;
  logic                     acc_neg, acc_ge;

  // Carry is always within [-3,2], so three signed bits are enough and t fits DW+1.
  always_comb begin
    digit   = digits_q[idx_q*DW +: DW];
    t       = $signed({digit[DW-1], digit}) + $signed({{LOGRADIX{carry_q[2]}}, carry_q});
    low_upd = low_q;
    low_upd[idx_q*LOGRADIX +: LOGRADIX] = t[LOGRADIX-1:0];
    mod_ext = $signed({3'b000, MODULUS});
    acc_neg = acc_q[AW-1];
    acc_ge  = (acc_q >= mod_ext);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)                state_d = CARRY;
      CARRY:   if (idx_q == LAST)           state_d = REDUCE;
      REDUCE:  if (!acc_neg && !acc_ge)     state_d = DONE;
      DONE:    if (out_ready)               state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    digits_d = digits_q;
    low_d    = low_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          digits_d = data_in;
          low_d    = '0;
          carry_d  = '0;
          idx_d    = '0;
        end
      end
      CARRY: begin
        low_d   = low_upd;
        carry_d = t[DW:LOGRADIX];
        idx_d   = idx_q + IDXW'(1);
        // The final carry becomes the sign-carrying top of the accumulator.
        if (idx_q == LAST) acc_d = $signed({t[DW:LOGRADIX], low_upd});
      end
      REDUCE: begin
        if (acc_neg)     acc_d  = acc_q + mod_ext;
        else if (acc_ge) acc_d  = acc_q - mod_ext;
        else             dout_d = acc_q[W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digits_q <= '0;
      low_q    <= '0;
      carry_q  <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      dout_q   <= '0;
    end else begin
      digits_q <= digits_d;
      low_q    <= low_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      dout_q   <= dout_d;
    end
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_polytocanonical.sv
// Directed bench for polytocanonical: expected residues and latencies come from
// an integer reference model and are queued at issue, popped when out_valid rises.
module tb_polytocanonical;
  localparam int NS = 4;
  localparam int LR = 4;
  localparam int DW = LR + 2;
  localparam int W  = NS * LR;
  localparam int M  = 65521;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [NS*DW-1:0] data_in;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    data_out;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int lat_q[$];

  always #5 clk = ~clk;

  polytocanonical #(
    .NUMSYMBOLS(NS),
    .LOGRADIX(LR),
    .MODULUS(16'hFFF1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NS*DW-1:0] pack(input int d0, input int d1, input int d2, input int d3);
    logic [NS*DW-1:0] p;
    p = '0;
    p[0*DW +: DW] = DW'(d0);
    p[1*DW +: DW] = DW'(d1);
    p[2*DW +: DW] = DW'(d2);
    p[3*DW +: DW] = DW'(d3);
    return p;
  endfunction

  // Residue by repeated +/-M; the step count is the number of correction cycles.
  function automatic int model(input int d0, input int d1, input int d2, input int d3, output int k);
    int v;
    v = d0 + d1 * 16 + d2 * 256 + d3 * 4096;
    k = 0;
    while (v < 0)  begin v += M; k++; end
    while (v >= M) begin v -= M; k++; end
    return v;
  endfunction

  task automatic issue(input int d0, input int d1, input int d2, input int d3, input string tag);
    int r, k;
    r = model(d0, d1, d2, d3, k);
    exp_q.push_back(r);
    lat_q.push_back(NS + 1 + k);
    check({tag, "_in_ready"}, in_ready, 1);
    data_in  = pack(d0, d1, d2, d3);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = '1;
  endtask

  task automatic await_result(input string tag);
    int cnt;
    int e, l;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!out_valid && cnt < 20);
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_latency"}, cnt, l);
    check({tag, "_data"}, data_out, e);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int seen;
    int r0, r1, r2, r3;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    issue(0, 0, 0, 0, "zero");       await_result("zero");  consume("zero");
    issue(15, 15, 15, 15, "all15");  await_result("all15"); consume("all15");
    issue(-1, 0, 0, 0, "neg1");      await_result("neg1");  consume("neg1");
    issue(31, 31, 31, 31, "all31");  await_result("all31"); consume("all31");
    issue(-32, -32, -32, -32, "allm32"); await_result("allm32"); consume("allm32");
    issue(1, 15, 15, 15, "eqmod");   await_result("eqmod"); consume("eqmod");

    // Stall the consumer while offering new work; nothing may change or be accepted.
    issue(31, 31, 31, 31, "stall");
    await_result("stall");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      data_in  = pack(1, 2, 3, 4);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("stall_valid_held", out_valid, 1);
      check("stall_data_held", data_out, 4397);
      check("stall_in_ready_low", in_ready, 0);
    end
    consume("stall");
    @(posedge clk); #1;
    check("stall_no_phantom_job", in_ready, 1);

    // Reset for one edge while mid-carry: the job must vanish.
    data_in  = pack(15, 15, 15, 15);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_data_out", data_out, 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_result", seen, 0);

    for (int j = 0; j < 4; j++) begin
      r0 = int'($urandom_range(0, 63)) - 32;
      r1 = int'($urandom_range(0, 63)) - 32;
      r2 = int'($urandom_range(0, 63)) - 32;
      r3 = int'($urandom_range(0, 63)) - 32;
      issue(r0, r1, r2, r3, "rand");
      await_result("rand");
      consume("rand");
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
